// File: rtl/piso_serial_tx.sv
// Framed parallel-in/serial-out transmitter: start bit 0, DATA_W payload bits LSB first, stop bit 1.
// Every serial bit is held for CLKS_PER_BIT clocks; one word is accepted per valid/ready handshake.
module piso_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              serial_q, serial_d;
  logic              done_q, done_d;
  logic              bit_end;
  logic [DATA_W-1:0] shift_nxt;

  assign bit_end   = (cnt_q == CNT_LAST);
  assign shift_nxt = shift_q >> 1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = bit_end ? '0 : cnt_q + CW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d    = '0;
        serial_d = 1'b1;
        if (tx_valid) begin
          state_d  = START;
          serial_d = 1'b0;
          shift_d  = tx_data;
          bit_d    = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d  = DATA;
          serial_d = shift_q[0];
          bit_d    = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
            state_d  = STOP;
            serial_d = 1'b1;
          end else begin
            // Next payload bit is the LSB of the register after this shift.
            bit_d    = bit_q + BW'(1);
            shift_d  = shift_nxt;
            serial_d = shift_nxt[0];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

  assign tx_ready  = (state_q == IDLE);
  assign tx_busy   = (state_q != IDLE);
  assign tx_serial = serial_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: a CLKS_PER_BIT=4 instance (index 0) and a CLKS_PER_BIT=1 instance (index 1).
module tb_piso_serial_tx;

  logic            clk;
  logic [1:0]      rst_n;
  logic [1:0][7:0] tx_data;
  logic [1:0]      tx_valid;
  logic [1:0]      tx_ready, tx_serial, tx_busy, tx_done;

  int n_cmp = 0;
  int n_err = 0;

  piso_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_cpb4 (
    .clk(clk), .rst_n(rst_n[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx_serial(tx_serial[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));

  piso_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u_cpb1 (
    .clk(clk), .rst_n(rst_n[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx_serial(tx_serial[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] pat;      // expected line level per bit slot, slot 0 = start bit
    int         sel;
    bit         disturb;  // change data and pulse valid mid-frame
  } vec_t;

  function automatic int cpb(int s);
    return (s == 0) ? 4 : 1;
  endfunction

  // Reference frame: start 0, payload LSB first, stop 1.
  function automatic logic [9:0] model_pat(logic [7:0] d);
    logic [9:0] p;
    p[0] = 1'b0;
    for (int i = 0; i < 8; i++) p[i+1] = d[i];
    p[9] = 1'b1;
    return p;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_chk(int s, string nm);
    chk({nm, "_serial"}, 32'(tx_serial[s]), 1);
    chk({nm, "_ready"},  32'(tx_ready[s]),  1);
    chk({nm, "_busy"},   32'(tx_busy[s]),   0);
    chk({nm, "_done"},   32'(tx_done[s]),   0);
  endtask

  task automatic accept(int s, logic [7:0] d, bit hold);
    @(negedge clk);
    chk("ready_before_accept", 32'(tx_ready[s]), 1);
    tx_data[s]  = d;
    tx_valid[s] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) tx_valid[s] = 1'b0;
  endtask

  // Called right after the acceptance edge; returns at the negedge of the tx_done cycle.
  task automatic run_frame(int s, logic [9:0] pat, bit disturb);
    int c = cpb(s);
    for (int k = 0; k < 10 * c; k++) begin
      @(negedge clk);
      chk("serial_bit", 32'(tx_serial[s]), 32'(pat[k / c]));
      chk("busy_in_frame",  32'(tx_busy[s]),  1);
      chk("ready_in_frame", 32'(tx_ready[s]), 0);
      chk("done_in_frame",  32'(tx_done[s]),  0);
      if (disturb && k == 15) begin
        tx_data[s]  = ~tx_data[s];
        tx_valid[s] = 1'b1;
      end
      if (disturb && k == 16) tx_valid[s] = 1'b0;
    end
    @(negedge clk);
    chk("done_pulse",    32'(tx_done[s]),   1);
    chk("ready_at_done", 32'(tx_ready[s]),  1);
    chk("busy_at_done",  32'(tx_busy[s]),   0);
    chk("serial_at_done", 32'(tx_serial[s]), 1);
  endtask

  vec_t vecs[7];
  time  t1, t2;

  initial begin
    vecs[0] = '{8'hA5, 10'b1101001010, 0, 1'b0};
    vecs[1] = '{8'h3C, 10'b1001111000, 0, 1'b1};
    vecs[2] = '{8'h81, 10'b1100000010, 0, 1'b0};
    vecs[3] = '{8'h00, 10'b1000000000, 0, 1'b0};
    vecs[4] = '{8'hFF, 10'b1111111110, 0, 1'b0};
    vecs[5] = '{8'hA5, 10'b1101001010, 1, 1'b0};
    vecs[6] = '{8'h81, 10'b1100000010, 1, 1'b0};

    rst_n    = 2'b00;
    tx_valid = 2'b00;
    tx_data  = '0;

    // Reset held for 3 cycles, then released.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_chk(0, "reset0");
      idle_chk(1, "reset1");
    end
    rst_n = 2'b11;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      idle_chk(0, "post_reset0");
      idle_chk(1, "post_reset1");
    end

    // Directed frames, including the mid-frame data/valid disturbance.
    foreach (vecs[i]) begin
      accept(vecs[i].sel, vecs[i].data, 1'b0);
      run_frame(vecs[i].sel, vecs[i].pat, vecs[i].disturb);
      @(negedge clk);
      idle_chk(vecs[i].sel, "after_frame");
      @(negedge clk);
      idle_chk(vecs[i].sel, "no_second_frame");
    end

    // Back-to-back with tx_valid held: data switched in the tx_done cycle.
    accept(0, 8'h00, 1'b1);
    run_frame(0, 10'b1000000000, 1'b0);
    t1 = $time;
    tx_data[0] = 8'hFF;
    @(posedge clk);
    run_frame(0, 10'b1111111110, 1'b0);
    t2 = $time;
    tx_valid[0] = 1'b0;
    chk("done_spacing", 32'((t2 - t1) / 20), 41);
    @(negedge clk);
    idle_chk(0, "after_b2b");

    // Asynchronous reset during data bit 3 of 8'h55.
    accept(0, 8'h55, 1'b0);
    for (int k = 0; k <= 17; k++) @(negedge clk);
    chk("bit3_level", 32'(tx_serial[0]), 0);
    #3 rst_n[0] = 1'b0;
    #1;
    idle_chk(0, "async_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_chk(0, "in_reset");
    end
    rst_n[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      idle_chk(0, "no_resume");
    end
    accept(0, 8'h81, 1'b0);
    run_frame(0, 10'b1100000010, 1'b0);
    @(negedge clk);
    idle_chk(0, "after_reset_frame");

    // Random words on both instances against the reference frame model.
    for (int i = 0; i < 24; i++) begin
      int         s;
      logic [7:0] d;
      s = int'($urandom_range(0, 1));
      d = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      accept(s, d, 1'b0);
      run_frame(s, model_pat(d), 1'b0);
      @(negedge clk);
      idle_chk(s, "rand_idle");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_serial_tx.md
Name: piso_serial_tx

Overview:
Parallel-in, serial-out framed bit transmitter. It is the driving end of the single-bit serial data line that the team's D-flip-flop capture stages sample.
- Accepts one DATA_W-bit word per valid/ready handshake.
- Emits the word on one line as a frame: start bit (0), data LSB first, stop bit (1).
- Each bit is held for CLKS_PER_BIT clock cycles.
- Sits between a parallel producer and a serial receiver/sampler.

Parameters:
DATA_W, 8, payload bits per frame; legal range 1 and up.
CLKS_PER_BIT, 4, clock cycles each serial bit is held; legal range 1 and up.

Ports:
clk  input  1  system clock, rising-edge active.
rst_n  input  1  asynchronous active-low reset.
tx_data  input  DATA_W  word to transmit; sampled only on the acceptance edge.
tx_valid  input  1  producer has a word on tx_data.
tx_ready  output  1  block can accept a word; high only in IDLE.
tx_serial  output  1  serial line, registered; idles high.
tx_busy  output  1  high while a frame is in progress (START, DATA, STOP).
tx_done  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Design rules
  - One clock; reset is asynchronous and active-low, ports named clk and rst_n.
  - All state updates on the rising edge of clk.
  - tx_serial and tx_done are registers.
  - tx_ready and tx_busy decode from state.
- Reset (rst_n=0, any time, including mid-frame)
  - Immediately: state=IDLE, tx_serial=1, tx_busy=0, tx_done=0, tx_ready=1.
  - Bit counter, cycle counter and shift register are cleared.
  - A partial frame is abandoned and never resumed.
- States: IDLE, START, DATA, STOP.
- Handshake
  - A transfer occurs on a rising edge where tx_valid=1 and tx_ready=1.
  - tx_data is latched into the shift register on that edge. Later changes to tx_data do not affect the frame.
  - tx_valid while not ready is ignored; there is no queueing.
- IDLE: tx_serial=1. On transfer, go to START, tx_serial<=0, cycle counter<=0.
- START
  - Hold 0 for CLKS_PER_BIT cycles.
  - On the last cycle, go to DATA and drive tx_serial<=shift[0].
- DATA
  - Each bit is held CLKS_PER_BIT cycles, LSB first; the shift register shifts right once per bit.
  - After bit DATA_W-1 completes, go to STOP with tx_serial<=1.
- STOP
  - Hold 1 for CLKS_PER_BIT cycles.
  - On the last cycle, go to IDLE and set tx_done<=1 for exactly one cycle.
- Latency and timing
  - Let acceptance edge be E.
  - tx_serial falls to 0 right after E.
  - The frame occupies exactly (DATA_W+2)*CLKS_PER_BIT cycles.
  - tx_done is high in the cycle beginning at E+(DATA_W+2)*CLKS_PER_BIT, and tx_ready is high in that same cycle.
- Back-to-back
  - If tx_valid is held high, the next word is accepted on the edge ending the tx_done cycle.
  - This gives exactly one idle-high cycle between stop bit and next start bit.
- Counters
  - Cycle counter width is $clog2(CLKS_PER_BIT)+1, with wrap compare at CLKS_PER_BIT-1.
  - Bit counter width is $clog2(DATA_W)+1.
  - CLKS_PER_BIT=1 must work: one cycle per bit, no zero-width vectors.
- Glitch freedom: tx_serial changes only on rising clk edges, or on reset assertion.

Test Plan:
All cases use DATA_W=8 and a 20 ns clk period.

1. Reset
   - Stimulus: rst_n=0 for 3 cycles, tx_valid=0.
   - Required: tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0 throughout; no change after rst_n rises.
2. Single frame, CLKS_PER_BIT=4
   - Stimulus: tx_data=8'hA5, tx_valid pulsed 1 cycle.
   - Required: tx_serial per 4-cycle bit = 0,1,0,1,0,0,1,0,1,1.
   - Required: tx_busy high for exactly 40 cycles; tx_done one pulse at cycle 40; tx_ready low during the frame.
3. Back-to-back, CLKS_PER_BIT=4
   - Stimulus: tx_valid held high, tx_data=8'h00 then 8'hFF, switched in the tx_done cycle.
   - Required: frame 1 has 9 low bits then a high stop bit; exactly 1 idle cycle of 1.
   - Required: frame 2 has start 0 then 9 high bits; two tx_done pulses, 41 cycles apart.
4. Data stability, CLKS_PER_BIT=4
   - Stimulus: accept 8'h3C, then change tx_data to 8'hC3 and toggle tx_valid mid-frame.
   - Required: serial payload stays 0,0,1,1,1,1,0,0; the mid-frame tx_valid causes no second frame.
5. Reset mid-frame
   - Stimulus: accept 8'h55, assert rst_n=0 asynchronously (not on a clk edge) during data bit 3.
   - Required: tx_serial goes to 1 immediately, with no tx_done pulse.
   - Required: after release, a new word 8'h81 transmits a clean, complete 40-cycle frame.
6. CLKS_PER_BIT=1 instance
   - Stimulus: send 8'hA5.
   - Required: tx_serial per cycle = 0,1,0,1,0,0,1,0,1,1; 10-cycle frame; tx_done in cycle 10.
